// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state encoding and
// default timing parameters used by the sequencer and its key debouncer.
package calc_pkg;

  // State codes double as the Step LED value, so the encoding is fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_A  = 3'd1,
    LOAD_A = 3'd2,
    WAIT_B = 3'd3,
    SET_B  = 3'd4,
    LOAD_B = 3'd5,
    SETTLE = 3'd6,
    SHOW   = 3'd7
  } state_t;

  localparam logic [15:0] DEBOUNCE_DEFAULT = 16'd50000;
  localparam logic [3:0]  SETTLE_DEFAULT   = 4'd4;

  // Bit positions inside the {Cout, Ovr, Zero, Neg} flag nibble.
  localparam int FLAG_COUT = 3;
  localparam int FLAG_OVR  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG  = 0;

endpackage

// File: rtl/calc_sequencer_if.sv
// Bus between the sequencer and the external arithmetic unit: operand bus,
// register load strobes, clear, operation select and the unit's flags.
interface calc_sequencer_if;

  logic [7:0] X;
  logic       InA;
  logic       InB;
  logic       Out;
  logic       Clear;
  logic       Add_Subtract;
  logic [3:0] Ccout;

  modport master (
    output X, InA, InB, Out, Clear, Add_Subtract,
    input  Ccout
  );

  modport slave (
    input  X, InA, InB, Out, Clear, Add_Subtract,
    output Ccout
  );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debouncer for the active-low enter key.
// Emits a single-cycle press pulse once the key has been seen pressed for
// DEBOUNCE_CYCLES consecutive samples; release must be equally stable
// before another press can be recognised.
module key_debounce
  import calc_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic CLR,
  input  logic KEY_n,
  output logic press
);

  // Internally the key is tracked as "pressed = 1" so everything resets to 0.
  logic        sync1;
  logic        sync2;
  logic        pressed_q;
  logic [15:0] cnt;

  // Bring the raw key into the clock domain.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~KEY_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that disagree with the accepted level; flip it and pulse on a new press.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pressed_q <= 1'b0;
      cnt       <= 16'd0;
      press     <= 1'b0;
    end else if (sync2 == pressed_q) begin
      cnt   <= 16'd0;
      press <= 1'b0;
    end else if (cnt >= DEBOUNCE_CYCLES - 16'd1) begin
      pressed_q <= sync2;
      cnt       <= 16'd0;
      press     <= sync2;
    end else begin
      cnt   <= cnt + 16'd1;
      press <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: walks an external arithmetic unit through loading
// operand A, loading operand B, waiting for the adder to settle, capturing
// the result flags and finally clearing, one debounced key press per step.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [3:0]  SETTLE_CYCLES   = SETTLE_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    KEY_n,
  input  logic [7:0]              SW,
  input  logic                    OP_SUB,
  calc_sequencer_if.master        bus,
  output logic [3:0]              Flags,
  output logic                    Busy,
  output logic [2:0]              Step
);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .CLK  (CLK),
    .CLR  (CLR),
    .KEY_n(KEY_n),
    .press(press)
  );

  // Main sequence; X is put on the bus one cycle before its load strobe and
  // held one cycle after, so the strobe edges never race the data.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state            <= IDLE;
      settle_cnt       <= 4'd0;
      bus.X            <= 8'd0;
      bus.InA          <= 1'b0;
      bus.InB          <= 1'b0;
      bus.Out          <= 1'b0;
      bus.Clear        <= 1'b1;
      bus.Add_Subtract <= 1'b0;
      Flags            <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.Clear <= 1'b0;
          if (press) begin
            state <= SET_A;
            bus.X <= SW;
          end
        end
        SET_A: begin
          state   <= LOAD_A;
          bus.InA <= 1'b1;
        end
        LOAD_A: begin
          state   <= WAIT_B;
          bus.InA <= 1'b0;
        end
        WAIT_B: begin
          if (press) begin
            state            <= SET_B;
            bus.X            <= SW;
            bus.Add_Subtract <= OP_SUB;
          end
        end
        SET_B: begin
          state   <= LOAD_B;
          bus.InB <= 1'b1;
        end
        LOAD_B: begin
          state      <= SETTLE;
          bus.InB    <= 1'b0;
          settle_cnt <= 4'd1;
          if (SETTLE_CYCLES <= 4'd1) begin
            bus.Out <= 1'b1;
            Flags   <= bus.Ccout;
          end
        end
        SETTLE: begin
          if (settle_cnt >= SETTLE_CYCLES) begin
            state   <= SHOW;
            bus.Out <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt + 4'd1 == SETTLE_CYCLES) begin
              bus.Out <= 1'b1;
              Flags   <= bus.Ccout;
            end
          end
        end
        SHOW: begin
          if (press) begin
            state     <= IDLE;
            bus.Clear <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Step = state;
  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer with a behavioural arithmetic unit.
// A second instance with a long settle window exercises presses during SETTLE.
module tb_calc_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       KEY_n = 1'b1;
  logic       key2_n = 1'b1;
  logic       OP_SUB = 1'b0;
  logic [7:0] SW = 8'd0;

  logic [3:0] Flags, flags2;
  logic       Busy, busy2;
  logic [2:0] Step, step2;

  calc_sequencer_if bus ();
  calc_sequencer_if bus2 ();

  calc_sequencer #(
    .DEBOUNCE_CYCLES(16'd4),
    .SETTLE_CYCLES  (4'd4)
  ) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .KEY_n (KEY_n),
    .SW    (SW),
    .OP_SUB(OP_SUB),
    .bus   (bus),
    .Flags (Flags),
    .Busy  (Busy),
    .Step  (Step)
  );

  calc_sequencer #(
    .DEBOUNCE_CYCLES(16'd4),
    .SETTLE_CYCLES  (4'd15)
  ) dut2 (
    .CLK   (CLK),
    .CLR   (CLR),
    .KEY_n (key2_n),
    .SW    (SW),
    .OP_SUB(OP_SUB),
    .bus   (bus2),
    .Flags (flags2),
    .Busy  (busy2),
    .Step  (step2)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  int cyc = 0;
  // Cycle counter used to time strobes.
  always @(posedge CLK) cyc <= cyc + 1;

  // Arithmetic unit stand-in: operand registers clocked by the load strobes.
  logic [7:0] reg_a = 8'd0;
  logic [7:0] reg_b = 8'd0;
  always @(posedge bus.InA) reg_a <= bus.X;
  always @(posedge bus.InB) reg_b <= bus.X;

  logic [7:0] bb;
  logic [8:0] sum9;
  logic [7:0] res;
  logic [3:0] unit_flags;
  // Combinational {Cout, Ovr, Zero, Neg} of reg_a +/- reg_b.
  always_comb begin
    bb         = bus.Add_Subtract ? ~reg_b : reg_b;
    sum9       = {1'b0, reg_a} + {1'b0, bb} + {8'd0, bus.Add_Subtract};
    res        = sum9[7:0];
    unit_flags = {sum9[8], (reg_a[7] == bb[7]) && (res[7] != reg_a[7]),
                  res == 8'd0, res[7]};
  end
  assign bus.Ccout  = unit_flags;
  assign bus2.Ccout = 4'b0000;

  // Strobe monitor, sampled on the falling edge.
  int         ina_hi = 0, inb_hi = 0, out_hi = 0, clear_hi = 0, out2_hi = 0;
  int         overlap = 0;
  int         ina_cyc = 0, inb_cyc = 0, out_cyc = 0;
  logic [7:0] x_at_ina = 8'd0, x_at_inb = 8'd0;
  always @(negedge CLK) begin
    if (bus.InA) begin
      ina_hi   <= ina_hi + 1;
      ina_cyc  <= cyc;
      x_at_ina <= bus.X;
    end
    if (bus.InB) begin
      inb_hi   <= inb_hi + 1;
      inb_cyc  <= cyc;
      x_at_inb <= bus.X;
    end
    if (bus.Out) begin
      out_hi  <= out_hi + 1;
      out_cyc <= cyc;
    end
    if (bus.Clear) clear_hi <= clear_hi + 1;
    if (bus2.Out) out2_hi <= out2_hi + 1;
    if (($countones({bus.InA, bus.InB, bus.Out, bus.Clear}) > 1) ||
        ($countones({bus2.InA, bus2.InB, bus2.Out, bus2.Clear}) > 1))
      overlap <= overlap + 1;
  end

  int tests = 0;
  int failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One clean key press on key 1 or 2: 8 cycles down, 8 cycles up.
  task automatic applyStimulus(input logic [7:0] sw_v, input logic sub_v,
                               input int which);
    SW     = sw_v;
    OP_SUB = sub_v;
    if (which == 1) KEY_n = 1'b0;
    else            key2_n = 1'b0;
    tick(8);
    KEY_n  = 1'b1;
    key2_n = 1'b1;
    tick(8);
  endtask

  task automatic waitStep(input string tag, input logic [2:0] want,
                          input int budget);
    int n = 0;
    while (Step != want && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {29'd0, Step}, {29'd0, want});
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int clear_before;
  int ina_before;
  int last_edge;

  initial begin
    // Reset state while CLR is held low.
    tick(3);
    checkOutput("rst_step",  {29'd0, Step}, 32'd0);
    checkOutput("rst_busy",  {31'd0, Busy}, 32'd0);
    checkOutput("rst_x",     {24'd0, bus.X}, 32'd0);
    checkOutput("rst_ina",   {31'd0, bus.InA}, 32'd0);
    checkOutput("rst_clear", {31'd0, bus.Clear}, 32'd1);
    checkOutput("rst_addsub", {31'd0, bus.Add_Subtract}, 32'd0);
    checkOutput("rst_flags", {28'd0, Flags}, 32'd0);
    CLR = 1'b1;
    tick(1);
    checkOutput("rst_clear_release", {31'd0, bus.Clear}, 32'd0);

    // 5 + 3: InA carries 05, InB carries 03, Out 4 cycles after InB, flags 0000.
    applyStimulus(8'h05, 1'b0, 1);
    waitStep("v1_waitb", 3'd3, 20);
    checkOutput("v1_ina_pulses", ina_hi, 32'd1);
    checkOutput("v1_x_at_ina", {24'd0, x_at_ina}, 32'h05);
    SW = 8'hAA;
    tick(3);
    checkOutput("v1_x_hold_waitb", {24'd0, bus.X}, 32'h05);
    applyStimulus(8'h03, 1'b0, 1);
    waitStep("v1_show", 3'd7, 30);
    checkOutput("v1_inb_pulses", inb_hi, 32'd1);
    checkOutput("v1_x_at_inb", {24'd0, x_at_inb}, 32'h03);
    checkOutput("v1_out_delay", out_cyc - inb_cyc, 32'd4);
    checkOutput("v1_out_pulses", out_hi, 32'd1);
    checkOutput("v1_flags", {28'd0, Flags}, 32'b0000);
    checkOutput("v1_busy", {31'd0, Busy}, 32'd1);
    clear_before = clear_hi;
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("v1_clear_pulse", clear_hi - clear_before, 32'd1);
    checkOutput("v1_idle", {29'd0, Step}, 32'd0);

    // 3 - 5 = -2: Neg set, Cout clear; OP_SUB change in SHOW must not leak.
    applyStimulus(8'd3, 1'b0, 1);
    applyStimulus(8'd5, 1'b1, 1);
    waitStep("v2_show", 3'd7, 30);
    checkOutput("v2_flags", {28'd0, Flags}, 32'b0001);
    OP_SUB = 1'b0;
    tick(3);
    checkOutput("v2_addsub_hold", {31'd0, bus.Add_Subtract}, 32'd1);
    applyStimulus(8'h00, 1'b0, 1);

    // 100 + 100 = 200: signed overflow, negative; press in SHOW clears once.
    applyStimulus(8'd100, 1'b0, 1);
    applyStimulus(8'd100, 1'b0, 1);
    waitStep("v3_show", 3'd7, 30);
    checkOutput("v3_flags", {28'd0, Flags}, 32'b0101);
    clear_before = clear_hi;
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("v3_clear_pulse", clear_hi - clear_before, 32'd1);
    checkOutput("v3_idle", {29'd0, Step}, 32'd0);

    // Long-settle instance: a press that lands in SETTLE is dropped, FSM stays in SHOW.
    applyStimulus(8'd7, 1'b0, 2);
    applyStimulus(8'd9, 1'b0, 2);
    applyStimulus(8'd0, 1'b0, 2);
    checkOutput("settle_press_step", {29'd0, step2}, 32'd7);
    checkOutput("settle_press_busy", {31'd0, busy2}, 32'd1);
    checkOutput("settle_out_pulses", out2_hi, 32'd1);

    // Reset in WAIT_B: everything back to idle, Clear held until release.
    applyStimulus(8'h5A, 1'b0, 1);
    waitStep("clr_waitb", 3'd3, 20);
    checkOutput("clr_x_before", {24'd0, bus.X}, 32'h5A);
    CLR = 1'b0;
    #1;
    checkOutput("clr_step", {29'd0, Step}, 32'd0);
    checkOutput("clr_x", {24'd0, bus.X}, 32'd0);
    checkOutput("clr_busy", {31'd0, Busy}, 32'd0);
    checkOutput("clr_flags", {28'd0, Flags}, 32'd0);
    tick(3);
    checkOutput("clr_clear_held", {31'd0, bus.Clear}, 32'd1);
    CLR = 1'b1;
    tick(1);
    checkOutput("clr_clear_release", {31'd0, bus.Clear}, 32'd0);

    // Bouncing key: 10 toggles every 2 cycles, then held low. Only the final
    // low level survives 4 samples. After the last edge: 2 sync cycles, 4
    // counted samples (press pulse after edge 6), SET_A after edge 7, InA after edge 8.
    ina_before = ina_hi;
    for (int i = 0; i < 10; i++) begin
      KEY_n = ~KEY_n;
      tick(2);
    end
    KEY_n = 1'b0;
    last_edge = cyc;
    tick(16);
    KEY_n = 1'b1;
    tick(10);
    checkOutput("bounce_ina_pulses", ina_hi - ina_before, 32'd1);
    checkOutput("bounce_latency", ina_cyc - last_edge, 32'd8);
    checkOutput("bounce_step", {29'd0, Step}, 32'd3);

    checkOutput("strobe_overlap", overlap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000, key-stable cycles before a press is accepted (16-bit counter).
REQ-002 Parameter SETTLE_CYCLES, default 4'd4, cycles between the InB pulse and the Out pulse, covering the adder ripple (4-bit counter).
REQ-003 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-004 CLR  in  1  asynchronous, active-low reset.
REQ-005 SW  in  8  operand switches.
REQ-006 KEY_n  in  1  raw enter pushbutton, active-low, asynchronous, bouncing.
REQ-007 OP_SUB  in  1  operation select: 0 add, 1 subtract.
REQ-008 Ccout  in  4  arithmetic-unit flags {Cout, Ovr, Zero, Neg}, combinational.
REQ-009 X  out  8  operand bus to the arithmetic unit.
REQ-010 InA / InB / Out  out  1 each  register load strobes; they serve as clocks for the unit's registers.
REQ-011 Clear  out  1  active-high clear to the arithmetic unit.
REQ-012 Add_Subtract  out  1  operation to the arithmetic unit.
REQ-013 Flags  out  4  Ccout captured on the Out pulse.
REQ-014 Busy  out  1  high whenever the FSM is outside IDLE.
REQ-015 Step  out  3  current state code, for LED display.

Function
REQ-016 KEY_n SHALL pass through a 2-flop synchronizer, then a debouncer; a press is accepted only after DEBOUNCE_CYCLES consecutive low samples.
REQ-017 Each accepted press SHALL produce exactly one 1-cycle press event; no new event until the key is released stable for DEBOUNCE_CYCLES.
REQ-018 FSM states: IDLE(0), SET_A(1), LOAD_A(2), WAIT_B(3), SET_B(4), LOAD_B(5), SETTLE(6), SHOW(7).
REQ-019 IDLE + press -> SET_A: X <= SW.
REQ-020 SET_A -> LOAD_A after 1 cycle; InA high for exactly that cycle.
REQ-021 LOAD_A -> WAIT_B; X SHALL stay unchanged from SET_A through the first WAIT_B cycle.
REQ-022 WAIT_B + press -> SET_B: X <= SW, Add_Subtract <= OP_SUB.
REQ-023 SET_B -> LOAD_B; InB high for exactly one cycle; X hold rule as in REQ-021.
REQ-024 LOAD_B -> SETTLE; remain SETTLE_CYCLES cycles; Out high during the last SETTLE cycle only; Flags <= Ccout on that same cycle.
REQ-025 SETTLE -> SHOW.
REQ-026 SHOW + press -> IDLE, with Clear high for exactly one cycle.
REQ-027 All strobes (InA, InB, Out, Clear) SHALL be driven directly from flops: glitch-free, never two high in the same cycle.
REQ-028 Press events SHALL be ignored in SET_A, LOAD_A, SET_B, LOAD_B and SETTLE; they are not queued.
REQ-029 SW and OP_SUB changes outside the SET_A/SET_B capture cycles SHALL NOT affect X or Add_Subtract.
REQ-030 Add_Subtract SHALL hold its value through SETTLE and SHOW.

Reset
REQ-031 CLR low SHALL, at any point including mid-sequence, force IDLE.
REQ-032 CLR low SHALL clear the debouncer, X, Flags, InA, InB and Out to 0.
REQ-033 CLR low SHALL set Add_Subtract=0, Busy=0, Step=0.
REQ-034 Clear SHALL be held high while CLR is low, and deassert on the first clock after release.

Structure
REQ-035 The state encoding and the default values of DEBOUNCE_CYCLES and SETTLE_CYCLES SHALL reside in shared package calc_pkg.
REQ-036 The synchronizer and debouncer SHALL form one sub-module, key_debounce (in: CLK, CLR, KEY_n; out: press pulse).

Verification (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=4)
REQ-037 SW=5, press; SW=3, OP_SUB=0, press -> one InA pulse with X=8'h05, one InB pulse with X=8'h03, Out pulse 4 cycles after InB, Flags=4'b0000.
REQ-038 Operands 3 then 5, OP_SUB=1 -> Flags Neg=1, Cout=0; Step reaches 7.
REQ-039 Operands 100 then 100, add -> Flags Ovr=1, Neg=1; a press in SHOW gives one Clear pulse and Step=0.
REQ-040 KEY_n toggles every 2 cycles for 20 cycles, then held low -> exactly one press event, accepted 4 stable cycles after the last edge.
REQ-041 Press during SETTLE -> ignored, FSM enters SHOW; CLR low during WAIT_B -> Step=0, X=0, Clear high until CLR is released.
REQ-042 Changing SW during WAIT_B -> X unchanged until the next press; no cycle ever has two strobes high.
